// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// Holds the access-type codes, access-size codes and the FSM state encoding
// used by mem_access_unit, mem_lane_align and their bench.
// Optional build macro affecting users of this package: MEM_ALIGN_CHECK_EN.
package mem_access_unit_pkg;

  // Access type: register-to-register, memory-to-register (load), register-to-memory (store)
  localparam logic [1:0] MEM_ACCESS_TYPE_R2R = 2'd0;
  localparam logic [1:0] MEM_ACCESS_TYPE_M2R = 2'd1;
  localparam logic [1:0] MEM_ACCESS_TYPE_R2M = 2'd2;

  // Access size; LEFT/RIGHT are the unaligned LWL/LWR/SWL/SWR forms
  localparam logic [2:0] MEM_ACCESS_LENGTH_BYTE       = 3'd0;
  localparam logic [2:0] MEM_ACCESS_LENGTH_HALF       = 3'd1;
  localparam logic [2:0] MEM_ACCESS_LENGTH_WORD       = 3'd2;
  localparam logic [2:0] MEM_ACCESS_LENGTH_LEFT_WORD  = 3'd3;
  localparam logic [2:0] MEM_ACCESS_LENGTH_RIGHT_WORD = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory bus interface between mem_access_unit (master) and memory (slave).
// Handshake: the master raises bus_req with bus_we/bus_addr/bus_byte_en/bus_wdata
// and holds all of them stable until the slave pulses bus_ready for exactly one
// cycle; on that cycle bus_rdata is valid and the transaction is complete.
// bus_ready while bus_req is low carries no meaning and is ignored.
// Ports (master view): out bus_req, bus_we, bus_addr[31:0] (word aligned),
// bus_byte_en[3:0], bus_wdata[31:0]; in bus_rdata[31:0], bus_ready.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering and merge logic (pure combinational).
// Ports: size[2:0], off[1:0] (addr[1:0]), load_signed, reg_val (store data or
// LWL/LWR merge value), mem_data (bus read data) ->
// store_be[3:0], store_data[31:0] (store steering), load_data[31:0] (load result).
// HALF uses only off[1]: with alignment checking disabled addr[0] is ignored.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic        load_signed,
  input  logic [31:0] reg_val,
  input  logic [31:0] mem_data,
  output logic [3:0]  store_be,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sh = mem_data >> {off, 3'b000};
  assign half_sh = mem_data >> {off[1], 4'b0000};
  assign byte_v  = byte_sh[7:0];
  assign half_v  = half_sh[15:0];

  always_comb begin
    store_be   = 4'b1111;
    store_data = reg_val;
    case (size)
      MEM_ACCESS_LENGTH_BYTE: begin
        store_be   = 4'b0001 << off;
        store_data = {4{reg_val[7:0]}};
      end
      MEM_ACCESS_LENGTH_HALF: begin
        store_be   = 4'b0011 << {off[1], 1'b0};
        store_data = {2{reg_val[15:0]}};
      end
      MEM_ACCESS_LENGTH_LEFT_WORD: begin
        // SWL writes the top bytes of the register into the low lanes
        case (off)
          2'd0:    store_be = 4'b0001;
          2'd1:    store_be = 4'b0011;
          2'd2:    store_be = 4'b0111;
          default: store_be = 4'b1111;
        endcase
        store_data = reg_val >> (5'd24 - {off, 3'b000});
      end
      MEM_ACCESS_LENGTH_RIGHT_WORD: begin
        store_be   = 4'b1111 << off;
        store_data = reg_val << {off, 3'b000};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = reg_val;
      end
    endcase
  end

  always_comb begin
    load_data = mem_data;
    case (size)
      MEM_ACCESS_LENGTH_BYTE:
        load_data = {{24{load_signed & byte_v[7]}}, byte_v};
      MEM_ACCESS_LENGTH_HALF:
        load_data = {{16{load_signed & half_v[15]}}, half_v};
      MEM_ACCESS_LENGTH_LEFT_WORD: begin
        case (off)
          2'd0:    load_data = {mem_data[7:0],  reg_val[23:0]};
          2'd1:    load_data = {mem_data[15:0], reg_val[15:0]};
          2'd2:    load_data = {mem_data[23:0], reg_val[7:0]};
          default: load_data = mem_data;
        endcase
      end
      MEM_ACCESS_LENGTH_RIGHT_WORD: begin
        case (off)
          2'd0:    load_data = mem_data;
          2'd1:    load_data = {reg_val[31:24], mem_data[31:8]};
          2'd2:    load_data = {reg_val[31:16], mem_data[31:16]};
          default: load_data = {reg_val[31:8],  mem_data[31:24]};
        endcase
      end
      default: load_data = mem_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: passes register results through and runs single
// outstanding loads/stores on a word bus, with byte steering and LWL/LWR merge.
// Ports: clk, rst_n (async, active low), flush, mem_access_type[1:0],
// mem_access_size[2:0], mem_load_signed, mem_access_addr[31:0], val_input[31:0],
// dest_reg_in[4:0], mem_bus (mem_access_unit_if.master), val_output[31:0],
// reg_addr_out[4:0], wb_valid, stall_for_mem, addr_error, fsm_state (debug).
// Build option: MEM_ALIGN_CHECK_EN enables misaligned HALF/WORD detection;
// when undefined addr_error is tied low and low address bits are ignored.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [1:0]          mem_access_type,
  input  logic [2:0]          mem_access_size,
  input  logic                mem_load_signed,
  input  logic [31:0]         mem_access_addr,
  input  logic [31:0]         val_input,
  input  logic [4:0]          dest_reg_in,
  mem_access_unit_if.master   mem_bus,
  output logic [31:0]         val_output,
  output logic [4:0]          reg_addr_out,
  output logic                wb_valid,
  output logic                stall_for_mem,
  output logic                addr_error,
  output mau_state_t          fsm_state
);

  mau_state_t  state, state_d;

  // Request captured at launch; the lane logic reads these while in BUS
  logic        is_store_q;
  logic [2:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [31:0] val_q;
  logic [4:0]  dest_q;
  logic        flush_q;

  logic        is_mem_in;
  logic        misaligned_in;
  logic        launch;

  logic        sel_idle;
  logic [2:0]  la_size;
  logic [1:0]  la_off;
  logic        la_signed;
  logic [31:0] la_val;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign is_mem_in = (mem_access_type == MEM_ACCESS_TYPE_M2R) ||
                     (mem_access_type == MEM_ACCESS_TYPE_R2M);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_in =
    ((mem_access_size == MEM_ACCESS_LENGTH_HALF) && mem_access_addr[0]) ||
    ((mem_access_size == MEM_ACCESS_LENGTH_WORD) && (mem_access_addr[1:0] != 2'b00));
`else
  assign misaligned_in = 1'b0;
`endif

  assign launch    = (state == IDLE) && is_mem_in && !flush && !misaligned_in;
  assign fsm_state = state;

  // In IDLE the lane logic steers the incoming store; afterwards it merges
  // the returning read data against the captured request.
  assign sel_idle  = (state == IDLE);
  assign la_size   = sel_idle ? mem_access_size      : size_q;
  assign la_off    = sel_idle ? mem_access_addr[1:0] : off_q;
  assign la_signed = sel_idle ? mem_load_signed      : signed_q;
  assign la_val    = sel_idle ? val_input            : val_q;

  mem_lane_align u_lane (
    .size        (la_size),
    .off         (la_off),
    .load_signed (la_signed),
    .reg_val     (la_val),
    .mem_data    (mem_bus.bus_rdata),
    .store_be    (st_be),
    .store_data  (st_wdata),
    .load_data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d       = state;
    stall_for_mem = 1'b0;
    case (state)
      IDLE: begin
        stall_for_mem = launch;
        if (launch) state_d = BUS;
      end
      BUS: begin
        stall_for_mem = 1'b1;
        if (mem_bus.bus_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q          <= 1'b0;
      size_q              <= 3'd0;
      signed_q            <= 1'b0;
      off_q               <= 2'd0;
      val_q               <= 32'd0;
      dest_q              <= 5'd0;
      flush_q             <= 1'b0;
      val_output          <= 32'd0;
      reg_addr_out        <= 5'd0;
      wb_valid            <= 1'b0;
      mem_bus.bus_req     <= 1'b0;
      mem_bus.bus_we      <= 1'b0;
      mem_bus.bus_addr    <= 32'd0;
      mem_bus.bus_byte_en <= 4'd0;
      mem_bus.bus_wdata   <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && (mem_access_type == MEM_ACCESS_TYPE_R2R)) begin
            val_output   <= val_input;
            reg_addr_out <= dest_reg_in;
            wb_valid     <= (dest_reg_in != 5'd0);
          end else if (launch) begin
            is_store_q          <= (mem_access_type == MEM_ACCESS_TYPE_R2M);
            size_q              <= mem_access_size;
            signed_q            <= mem_load_signed;
            off_q               <= mem_access_addr[1:0];
            val_q               <= val_input;
            dest_q              <= dest_reg_in;
            flush_q             <= 1'b0;
            mem_bus.bus_req     <= 1'b1;
            mem_bus.bus_we      <= (mem_access_type == MEM_ACCESS_TYPE_R2M);
            mem_bus.bus_addr    <= {mem_access_addr[31:2], 2'b00};
            if (mem_access_type == MEM_ACCESS_TYPE_R2M) begin
              mem_bus.bus_byte_en <= st_be;
              mem_bus.bus_wdata   <= st_wdata;
            end else begin
              mem_bus.bus_byte_en <= 4'b1111;
              mem_bus.bus_wdata   <= 32'd0;
            end
          end
        end
        BUS: begin
          // A flush here cannot abort the bus cycle; it only kills writeback
          if (flush) flush_q <= 1'b1;
          if (mem_bus.bus_ready) begin
            mem_bus.bus_req     <= 1'b0;
            mem_bus.bus_we      <= 1'b0;
            mem_bus.bus_addr    <= 32'd0;
            mem_bus.bus_byte_en <= 4'd0;
            mem_bus.bus_wdata   <= 32'd0;
            if (!is_store_q && !flush_q && !flush) begin
              val_output   <= ld_data;
              reg_addr_out <= dest_q;
              wb_valid     <= (dest_q != 5'd0);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_error <= 1'b0;
    else        addr_error <= (state == IDLE) && is_mem_in && !flush && misaligned_in;
  end
`else
  assign addr_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Expected writebacks and bus requests are
// queued when stimulus is issued; a negedge monitor pops and compares them.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  mem_access_type;
  logic [2:0]  mem_access_size;
  logic        mem_load_signed;
  logic [31:0] mem_access_addr;
  logic [31:0] val_input;
  logic [4:0]  dest_reg_in;
  logic [31:0] val_output;
  logic [4:0]  reg_addr_out;
  logic        wb_valid;
  logic        stall_for_mem;
  logic        addr_error;
  mau_state_t  fsm_state;

  mem_access_unit_if mem_bus ();

  mem_access_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .mem_access_type (mem_access_type),
    .mem_access_size (mem_access_size),
    .mem_load_signed (mem_load_signed),
    .mem_access_addr (mem_access_addr),
    .val_input       (val_input),
    .dest_reg_in     (dest_reg_in),
    .mem_bus         (mem_bus.master),
    .val_output      (val_output),
    .reg_addr_out    (reg_addr_out),
    .wb_valid        (wb_valid),
    .stall_for_mem   (stall_for_mem),
    .addr_error      (addr_error),
    .fsm_state       (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [36:0] wb_exp_q[$];   // {reg_addr_out, val_output}
  logic [68:0] bus_exp_q[$];  // {we, addr, byte_en, wdata}
  logic        req_prev = 1'b0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (wb_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got reg=%0d val=%h expected no writeback",
                   reg_addr_out, val_output);
        end else begin
          check("wb_data", {32'd0, reg_addr_out, val_output}, {32'd0, wb_exp_q.pop_front()});
        end
      end
      if (mem_bus.bus_req && !req_prev) begin
        if (bus_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got addr=%h expected no request", mem_bus.bus_addr);
        end else begin
          check("bus_req_fields",
                {mem_bus.bus_we, mem_bus.bus_addr, mem_bus.bus_byte_en, mem_bus.bus_wdata},
                bus_exp_q.pop_front());
        end
      end
    end
    req_prev = mem_bus.bus_req;
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    mem_access_type = MEM_ACCESS_TYPE_R2R;
    mem_access_size = MEM_ACCESS_LENGTH_WORD;
    mem_load_signed = 1'b0;
    mem_access_addr = 32'd0;
    val_input       = 32'd0;
    dest_reg_in     = 5'd0;
    flush           = 1'b0;
  endtask

  task automatic r2r_op(input logic [31:0] v, input logic [4:0] d);
    @(posedge clk); #1;
    mem_access_type = MEM_ACCESS_TYPE_R2R;
    val_input       = v;
    dest_reg_in     = d;
    if (d != 5'd0) wb_exp_q.push_back({d, v});
    @(negedge clk);
    check("r2r_no_stall", {68'd0, stall_for_mem}, 69'd0);
    check("r2r_no_bus_req", {68'd0, mem_bus.bus_req}, 69'd0);
  endtask

  // One bus access; bus_ready is withheld for 'waits' BUS cycles, then pulsed.
  // fl raises flush during the first BUS cycle.
  task automatic mem_op(input logic [1:0] t, input logic [2:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] v, input logic [4:0] d,
                        input logic [31:0] rd, input int waits, input logic fl,
                        input logic exp_we, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_val);
    int stall_cnt;
    @(posedge clk); #1;
    mem_access_type = t;
    mem_access_size = sz;
    mem_load_signed = sgn;
    mem_access_addr = a;
    val_input       = v;
    dest_reg_in     = d;
    flush           = 1'b0;
    bus_exp_q.push_back({exp_we, exp_addr, exp_be, exp_wdata});
    if (t == MEM_ACCESS_TYPE_M2R && d != 5'd0 && !fl) wb_exp_q.push_back({d, exp_val});
    @(negedge clk);
    check("launch_stall", {68'd0, stall_for_mem}, 69'd1);
    @(posedge clk); #1;
    idle_inputs();
    flush = fl;
    stall_cnt = 0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (stall_for_mem) stall_cnt++;
      check("bus_wait_req", {68'd0, mem_bus.bus_req}, 69'd1);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    mem_bus.bus_ready = 1'b1;
    mem_bus.bus_rdata = rd;
    @(negedge clk);
    if (stall_for_mem) stall_cnt++;
    check("bus_state", {67'd0, fsm_state}, {67'd0, BUS});
    @(posedge clk); #1;
    mem_bus.bus_ready = 1'b0;
    mem_bus.bus_rdata = 32'h0;
    flush = 1'b0;
    @(negedge clk);
    check("done_state", {67'd0, fsm_state}, {67'd0, DONE});
    check("done_no_stall", {68'd0, stall_for_mem}, 69'd0);
    check("done_req_low", {68'd0, mem_bus.bus_req}, 69'd0);
    check("bus_stall_cycles", 69'(stall_cnt), 69'(waits + 1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    mem_bus.bus_ready = 1'b0;
    mem_bus.bus_rdata = 32'h0;
    #3;
    check("reset_outputs",
          {mem_bus.bus_req, mem_bus.bus_we, mem_bus.bus_addr, mem_bus.bus_byte_en,
           wb_valid, stall_for_mem, addr_error, reg_addr_out, 23'd0},
          69'd0);
    check("reset_val_output", {37'd0, val_output}, 69'd0);
    check("reset_state", {67'd0, fsm_state}, {67'd0, IDLE});
    @(negedge clk); @(negedge clk); #2;
    rst_n = 1'b1;

    // R2R writeback, then dest 0 must not write back
    r2r_op(32'h12345678, 5'd5);
    r2r_op(32'hDEADDEAD, 5'd0);

    // LB signed, off 3, 3 wait cycles
    mem_op(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_BYTE, 1'b1, 32'h103, 32'h0, 5'd7,
           32'h80FFFFFF, 3, 1'b0, 1'b0, 32'h100, 4'b1111, 32'h0, 32'hFFFFFF80);
    // SWR off 2
    mem_op(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_RIGHT_WORD, 1'b0, 32'h22, 32'hAABBCCDD, 5'd0,
           32'h0, 0, 1'b0, 1'b1, 32'h20, 4'b1100, 32'hCCDD0000, 32'h0);
    // LWL off 1
    mem_op(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_LEFT_WORD, 1'b0, 32'h41, 32'h11223344, 5'd9,
           32'hA1B2C3D4, 1, 1'b0, 1'b0, 32'h40, 4'b1111, 32'h0, 32'hC3D43344);
    // LWR off 2
    mem_op(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_RIGHT_WORD, 1'b0, 32'h12, 32'h11223344, 5'd4,
           32'hA1B2C3D4, 0, 1'b0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'h1122A1B2);
    // LHU upper half, zero extended
    mem_op(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_HALF, 1'b0, 32'h12, 32'h0, 5'd3,
           32'h87654321, 2, 1'b0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'h00008765);
    // SB off 1, SH off 2, SWL off 1, SW
    mem_op(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_BYTE, 1'b0, 32'h1, 32'h000000EE, 5'd1,
           32'h0, 1, 1'b0, 1'b1, 32'h0, 4'b0010, 32'hEEEEEEEE, 32'h0);
    mem_op(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_HALF, 1'b0, 32'h2, 32'h0000BEEF, 5'd0,
           32'h0, 0, 1'b0, 1'b1, 32'h0, 4'b1100, 32'hBEEFBEEF, 32'h0);
    mem_op(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_LEFT_WORD, 1'b0, 32'h31, 32'hAABBCCDD, 5'd0,
           32'h0, 0, 1'b0, 1'b1, 32'h30, 4'b0011, 32'h0000AABB, 32'h0);
    mem_op(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h50, 32'hDEADBEEF, 5'd2,
           32'h0, 0, 1'b0, 1'b1, 32'h50, 4'b1111, 32'hDEADBEEF, 32'h0);
    // Load to r0: bus access but no writeback
    mem_op(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h54, 32'h0, 5'd0,
           32'h55555555, 0, 1'b0, 1'b0, 32'h54, 4'b1111, 32'h0, 32'h0);
    // Flush during BUS: bus completes, writeback suppressed
    mem_op(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h60, 32'h0, 5'd6,
           32'h66666666, 2, 1'b1, 1'b0, 32'h60, 4'b1111, 32'h0, 32'h0);

    // Flush in IDLE: nothing launched
    @(posedge clk); #1;
    mem_access_type = MEM_ACCESS_TYPE_M2R;
    mem_access_addr = 32'h80;
    dest_reg_in     = 5'd2;
    flush           = 1'b1;
    @(negedge clk);
    check("idle_flush_no_stall", {68'd0, stall_for_mem}, 69'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("idle_flush_no_req", {68'd0, mem_bus.bus_req}, 69'd0);
    check("idle_flush_state", {67'd0, fsm_state}, {67'd0, IDLE});

    // Stray bus_ready in IDLE is ignored
    @(posedge clk); #1;
    mem_bus.bus_ready = 1'b1;
    mem_bus.bus_rdata = 32'h77777777;
    @(negedge clk);
    @(posedge clk); #1;
    mem_bus.bus_ready = 1'b0;
    @(negedge clk);
    check("stray_ready_state", {67'd0, fsm_state}, {67'd0, IDLE});

    // Reset while in BUS
    @(posedge clk); #1;
    mem_access_type = MEM_ACCESS_TYPE_M2R;
    mem_access_size = MEM_ACCESS_LENGTH_WORD;
    mem_access_addr = 32'h70;
    dest_reg_in     = 5'd8;
    bus_exp_q.push_back({1'b0, 32'h70, 4'b1111, 32'h0});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("pre_reset_bus_state", {67'd0, fsm_state}, {67'd0, BUS});
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_bus_reset_req", {68'd0, mem_bus.bus_req}, 69'd0);
    check("mid_bus_reset_state", {67'd0, fsm_state}, {67'd0, IDLE});
    check("mid_bus_reset_stall", {68'd0, stall_for_mem}, 69'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned LW: error pulse, no bus access
    @(posedge clk); #1;
    mem_access_type = MEM_ACCESS_TYPE_M2R;
    mem_access_size = MEM_ACCESS_LENGTH_WORD;
    mem_access_addr = 32'h102;
    dest_reg_in     = 5'd5;
    @(negedge clk);
    check("misalign_no_stall", {68'd0, stall_for_mem}, 69'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("misalign_addr_error", {68'd0, addr_error}, 69'd1);
    check("misalign_no_req", {68'd0, mem_bus.bus_req}, 69'd0);
    check("misalign_state", {67'd0, fsm_state}, {67'd0, IDLE});
    @(posedge clk); #1;
    @(negedge clk);
    check("misalign_error_pulse", {68'd0, addr_error}, 69'd0);
`else
    // Without checking, LW at 0x102 goes to the word at 0x100
    mem_op(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h102, 32'h0, 5'd5,
           32'hCAFEF00D, 1, 1'b0, 1'b0, 32'h100, 4'b1111, 32'h0, 32'hCAFEF00D);
    check("addr_error_tied", {68'd0, addr_error}, 69'd0);
`endif

    repeat (3) @(negedge clk);
    check("wb_queue_drained", 69'(wb_exp_q.size()), 69'd0);
    check("bus_queue_drained", 69'(bus_exp_q.size()), 69'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- flush, in, 1: exception flush; kills the current instruction.
- mem_access_type, in, 2: R2R / M2R / R2M, encoded per the shared defs.
- mem_access_size, in, 3: BYTE / HALF / WORD / LEFT_WORD / RIGHT_WORD.
- mem_load_signed, in, 1: sign-extend BYTE/HALF loads.
- mem_access_addr, in, 32: byte address from EX.
- val_input, in, 32: EX result, store data, or LWL/LWR merge value.
- dest_reg_in, in, 5: destination register.
- bus_req, out, 1; bus_we, out, 1; bus_addr, out, 32 (word-aligned); bus_byte_en, out, 4; bus_wdata, out, 32.
- bus_rdata, in, 32; bus_ready, in, 1: one-cycle completion strobe.
- val_output, out, 32: writeback value.
- reg_addr_out, out, 5: writeback register.
- wb_valid, out, 1: writeback strobe.
- stall_for_mem, out, 1: holds the upstream pipeline.
- addr_error, out, 1: alignment fault pulse.

REQ-002 SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-003 SHALL use FSM states IDLE, BUS, DONE.
REQ-004 IDLE, type R2R, no flush: next edge registers val_output=val_input and reg_addr_out=dest_reg_in; wb_valid=1 iff dest_reg_in!=0.
REQ-005 IDLE, type M2R/R2M, no flush, aligned: latch the request, go to BUS; stall_for_mem=1 combinationally in that same cycle.
REQ-006 BUS drives these outputs from registers and holds them stable until bus_ready:
- bus_req=1.
- bus_we=1 for R2M.
- bus_addr={addr[31:2],2'b00}.
REQ-007 BUS: on bus_ready, capture and merge bus_rdata, go to DONE; bus_req drops on the next edge.
REQ-008 DONE: wb_valid=1 for one cycle for loads with dest!=0 (never for stores), stall_for_mem=0, inputs ignored; next state IDLE.
REQ-009 stall_for_mem = (IDLE and access pending and no flush) or BUS.
REQ-010 Store byte enables and data, little-endian, off=addr[1:0]:
- BYTE: be=1<<off, data=byte replicated.
- HALF: be=0011<<off, data=half replicated.
- WORD: be=1111.
- LEFT_WORD (SWL), off 0..3: be=0001/0011/0111/1111, data=val>>(24-8*off).
- RIGHT_WORD (SWR), off 0..3: be=1111/1110/1100/1000, data=val<<(8*off).
REQ-011 Load results, m=bus_rdata, r=val_input:
- BYTE/HALF: the selected lane, sign- or zero-extended per mem_load_signed.
- LWL, off 0..3: {m[7:0],r[23:0]}, {m[15:0],r[15:0]}, {m[23:0],r[7:0]}, m.
- LWR, off 0..3: m, {r[31:24],m[31:8]}, {r[31:16],m[31:16]}, {r[31:8],m[31:24]}.
- Loads drive bus_byte_en=1111.
REQ-012 Flush in IDLE: no access is launched and wb_valid=0.
REQ-013 Flush in BUS: the bus transaction still completes; wb_valid is suppressed in DONE.
REQ-014 A bus_ready seen outside BUS SHALL be ignored.

Reset
REQ-015 Reset SHALL force state=IDLE and clear every output to 0, including mid-BUS (bus_req drops immediately).

Configuration
REQ-016 With MEM_ALIGN_CHECK_EN defined, a misaligned access (HALF addr[0]!=0; WORD addr[1:0]!=0) SHALL do the following:
- no bus access is launched.
- addr_error=1 for one cycle on the next edge.
- wb_valid=0 and stall_for_mem=0.
LEFT_WORD and RIGHT_WORD are never misaligned.
REQ-017 Without MEM_ALIGN_CHECK_EN, addr_error SHALL be tied 0; HALF ignores addr[0] and WORD ignores addr[1:0].

Structure
REQ-018 The shared defs package SHALL hold the MEM_ACCESS_TYPE_* and MEM_ACCESS_LENGTH_* codes and the FSM state encoding.
REQ-019 Lane steering and merge logic SHALL sit in one sub-module, mem_lane_align (pure combinational); the FSM stays in mem_access_unit.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- R2R, val_input=0x12345678, dest=5 -> next cycle val_output=0x12345678, reg_addr_out=5, wb_valid=1, no bus_req.
- LB signed, addr=0x103, rdata=0x80FFFFFF, bus_ready after 3 wait cycles -> bus_addr=0x100, stall held 4 cycles, val_output=0xFFFFFF80, wb_valid=1 in DONE.
- SWR, addr=0x22, val=0xAABBCCDD -> bus_we=1, bus_byte_en=1100, bus_wdata=0xCCDD0000.
- LWL, off=1, r=0x11223344, m=0xA1B2C3D4 -> val_output=0xC3D43344.
- Flush during BUS, then bus_ready -> bus completes, wb_valid stays 0; separately, rst_n low mid-BUS -> bus_req=0 immediately, state IDLE.
- MEM_ALIGN_CHECK_EN, LW addr=0x102 -> addr_error=1 for one cycle, no bus_req; without the macro -> bus_addr=0x100.
